icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped, read-only instruction cache that answers instruction-fetch requests from the fetch stage.
- Returns a hit in the same cycle as the request. On a miss, refills a whole line from instruction memory one word per beat, then returns the missed word.
- Sits between the fetch stage and the instruction-memory port.

Parameters:
LINES, 64, number of cache lines (power of 2, >=2)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  fetch request, valid for addr this cycle
cpu_addr  input  32  byte address of instruction (bits[1:0] ignored)
cpu_data  output  32  instruction word
cpu_valid  output  1  cpu_data valid for the current/latched address
mem_req  output  1  refill beat request
mem_addr  output  32  word-aligned refill beat address
mem_rdata  input  32  refill beat data
mem_rvalid  input  1  refill beat accepted/returned this cycle

Behaviour:
- Interface decisions:
  - Single clock clk.
  - rst_n is asynchronous, active-low.
  - Address split: OFF = log2(LINE_WORDS)+2 bits, IDX = log2(LINES) bits, TAG = remaining upper bits.
- Storage:
  - Per line: valid bit, tag, and LINE_WORDS data words.
  - Arrays are read combinationally.
- States:
  - IDLE: hit = cpu_req && valid[idx] && tag match.
    - On hit, cpu_valid=1 and cpu_data=word[idx][woff] combinationally in the same cycle; stay in IDLE.
    - On cpu_req && !hit: latch cpu_addr into miss_addr, clear beat counter, go to REFILL; cpu_valid=0.
  - REFILL: mem_req=1, mem_addr={miss_addr line base, beat, 2'b00}.
    - Each cycle with mem_rvalid=1: write mem_rdata into word[beat] of the line, beat++.
    - On the last beat: write tag, set valid, go to RESP.
    - cpu_req and cpu_addr are ignored in REFILL; the requester holds its address.
  - RESP (one cycle): cpu_valid=1, cpu_data=word of miss_addr, then IDLE. Asserted regardless of cpu_req.
- Beat order: always starts at word 0 of the line and increments; no critical-word-first.
- mem_req: held high through the whole REFILL state; deasserted in IDLE and RESP.
- Outputs when not valid: cpu_data=32'h0000_0013 (NOP) whenever cpu_valid=0.
- Reset (any time, including mid-refill):
  - State -> IDLE; all valid bits cleared; beat -> 0.
  - mem_req=0, cpu_valid=0, cpu_data=NOP.
  - Data and tag arrays need no reset.
- Boundaries:
  - Index wrap is naturally handled by the address split.
  - A hit request in the cycle after RESP is served normally.
  - The last word of a line (offset LINE_WORDS-1) is refilled and returned correctly.
  - A refill overwrites any previous line at that index.

Optional Feature:
- Macro ICACHE_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 in IDLE: all valid bits clear at the next edge; cpu_valid is forced 0 that cycle.
  - flush=1 during REFILL: the refill completes and RESP still returns the word, but the line is left invalid at the end of the refill.
  - flush in RESP: RESP completes, all valid bits clear.
- When undefined: no flush port; valid bits clear only on reset.

Test Plan:
- After reset, cpu_req=1, addr=0x100 -> cpu_valid=0, REFILL with mem_addr 0x100,0x104,0x108,0x10C (LINE_WORDS=4). After the 4th mem_rvalid, one RESP cycle with cpu_valid=1 and cpu_data=beat0 data.
- Following cycle, addr=0x108 -> cpu_valid=1 same cycle, cpu_data=3rd beat data, mem_req stays 0.
- Conflict: addr=0x100 then 0x500 (same index, LINES=64, different tag) -> second request misses and refills. A re-request of 0x100 then misses again.
- mem_rvalid stalls (gaps of 3 cycles between beats) -> mem_req stays high, beats written in order, RESP only after the 4th beat.
- rst_n pulsed low mid-REFILL after 2 beats -> mem_req drops immediately, cpu_valid=0. Re-request of 0x100 performs a full 4-beat refill.
- ICACHE_FLUSH_EN: hit on 0x100, pulse flush, re-request 0x100 -> miss and refill. flush during REFILL -> RESP returns data, and the next request to the same line misses.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache between fetch stage and instruction memory.
// Latency: hit answered combinationally in the request cycle; miss = LINE_WORDS refill beats + 1 RESP cycle.
// Backpressure: refill waits on mem_rvalid per beat; cpu_req/cpu_addr ignored while refilling (requester holds).
//
// Ports: clk, rst_n (async active-low); cpu_req/cpu_addr in, cpu_data/cpu_valid out (fetch side);
//        mem_req/mem_addr out, mem_rdata/mem_rvalid in (refill side).
// Optional: define ICACHE_FLUSH_EN to add a 'flush' input that invalidates all lines.
module icache #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ICACHE_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_data,
  output logic        cpu_valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int OFF = $clog2(LINE_WORDS) + 2;
  localparam int IDX = $clog2(LINES);
  localparam int TAG = 32 - OFF - IDX;
  localparam int WB  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t           state;
  logic [LINES-1:0] valid;
  logic [TAG-1:0]   tags  [LINES];
  logic [31:0]      words [LINES][LINE_WORDS];
  logic [31:0]      miss_addr;
  logic [WB-1:0]    beat;
  logic             flush_pend;  // a flush arrived during the current refill

  logic flush_i;
`ifdef ICACHE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  function automatic logic [IDX-1:0] idx_of(input logic [31:0] a);
    return IDX'(a >> OFF);
  endfunction

  function automatic logic [TAG-1:0] tag_of(input logic [31:0] a);
    return TAG'(a >> (OFF + IDX));
  endfunction

  function automatic logic [WB-1:0] woff_of(input logic [31:0] a);
    return WB'((a >> 2) & 32'(LINE_WORDS - 1));
  endfunction

  logic [IDX-1:0] req_idx, m_idx;
  logic [TAG-1:0] req_tag, m_tag;
  logic [WB-1:0]  req_woff, m_woff;
  logic           hit, last_beat;
  logic           unused_bits;

  assign req_idx   = idx_of(cpu_addr);
  assign req_tag   = tag_of(cpu_addr);
  assign req_woff  = woff_of(cpu_addr);
  assign m_idx     = idx_of(miss_addr);
  assign m_tag     = tag_of(miss_addr);
  assign m_woff    = woff_of(miss_addr);
  assign last_beat = (beat == WB'(LINE_WORDS - 1));
  assign unused_bits = ^{cpu_addr[1:0], miss_addr[1:0]};

  // A flush in IDLE suppresses the hit so stale data never escapes that cycle.
  assign hit = (state == IDLE) && cpu_req && !flush_i && valid[req_idx] && (tags[req_idx] == req_tag);

  always_comb begin
    cpu_valid = 1'b0;
    cpu_data  = NOP;
    if (hit) begin
      cpu_valid = 1'b1;
      cpu_data  = words[req_idx][req_woff];
    end else if (state == RESP) begin
      cpu_valid = 1'b1;
      cpu_data  = words[m_idx][m_woff];
    end
  end

  assign mem_req  = (state == REFILL);
  assign mem_addr = (miss_addr & ~LINE_MASK) | (32'(beat) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      beat       <= '0;
      miss_addr  <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_i) begin
            valid <= '0;
          end else if (cpu_req && !hit) begin
            miss_addr  <= cpu_addr;
            beat       <= '0;
            flush_pend <= 1'b0;
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (flush_i) flush_pend <= 1'b1;
          if (mem_rvalid) begin
            beat <= beat + WB'(1);
            if (last_beat) begin
              // A flush seen at any point of the refill wins over installing the line.
              if (flush_pend || flush_i) valid <= '0;
              else                       valid[m_idx] <= 1'b1;
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (flush_i) valid <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data/tag arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_rvalid) begin
      words[m_idx][beat] <= mem_rdata;
      if (last_beat) tags[m_idx] <= m_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache (table vectors, hand sequences, randomized fetches vs. a line-level model).
module tb_icache;
  localparam int LINES = 64;
  localparam int LW    = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_data;
  logic        cpu_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
`ifdef ICACHE_FLUSH_EN
  logic        flush = 1'b0;
`endif

  always #5 clk = ~clk;

  icache #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ICACHE_FLUSH_EN
    .flush     (flush),
`endif
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_valid (cpu_valid),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  // Reference model: one entry per line, computed from byte address arithmetic.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES][LW];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch, starting with the DUT in IDLE. flush_beat >= 0 raises flush during that refill beat.
  task automatic do_fetch(input logic [31:0] a, input int gap, input int flush_beat, output bit got_hit);
    int          idx;
    int unsigned tg;
    logic [31:0] base;
    bit          exp_hit;
    idx     = int'((a / (LW * 4)) % LINES);
    tg      = a / (LW * 4 * LINES);
    base    = a - (a % (LW * 4));
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    cpu_req = 1'b1; cpu_addr = a; mem_rvalid = 1'b0;
    @(negedge clk);
    got_hit = cpu_valid;
    chk("req_hit", 32'(cpu_valid), 32'(exp_hit));
    chk("req_mem_req", 32'(mem_req), 32'd0);
    if (exp_hit) chk("hit_data", cpu_data, m_data[idx][(a / 4) % LW]);
    else         chk("miss_nop", cpu_data, NOP);
    @(posedge clk); #1;
    if (!exp_hit) begin
      for (int b = 0; b < LW; b++) begin
        for (int g = 0; g < gap; g++) begin
          mem_rvalid = 1'b0;
          @(negedge clk);
          chk("stall_mem_req", 32'(mem_req), 32'd1);
          chk("stall_valid", 32'(cpu_valid), 32'd0);
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = memfn(base + 32'(4 * b));
`ifdef ICACHE_FLUSH_EN
        if (b == flush_beat) flush = 1'b1;
`endif
        @(negedge clk);
        chk("beat_addr", mem_addr, base + 32'(4 * b));
        chk("beat_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
`ifdef ICACHE_FLUSH_EN
        flush = 1'b0;
`endif
      end
      mem_rvalid = 1'b0;
      for (int w = 0; w < LW; w++) m_data[idx][w] = memfn(base + 32'(4 * w));
      if (flush_beat >= 0) model_clear();
      else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
      @(negedge clk);
      chk("resp_valid", 32'(cpu_valid), 32'd1);
      chk("resp_data", cpu_data, memfn(a & ~32'd3));
      chk("resp_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          gap;
    bit          exp_hit;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[13];
    bit   got;
    vecs = '{
      '{32'h0000_0100, 0, 1'b0},  // cold miss
      '{32'h0000_0108, 0, 1'b1},  // hit right after RESP
      '{32'h0000_0500, 0, 1'b0},  // same index, other tag
      '{32'h0000_0100, 0, 1'b0},  // evicted, misses again
      '{32'h0000_010C, 0, 1'b1},  // last word of line
      '{32'h0000_03F4, 1, 1'b0},  // top index
      '{32'h0000_03FC, 0, 1'b1},
      '{32'h0000_0400, 0, 1'b0},  // index wraps to 0
      '{32'h0000_0404, 0, 1'b1},
      '{32'h0000_0204, 3, 1'b0},  // 3-cycle gaps between beats
      '{32'h0000_0200, 0, 1'b1},
      '{32'h0000_0500, 0, 1'b0},
      '{32'h0000_0106, 0, 1'b0}   // low bits ignored
    };
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    chk("rst_cpu_data", cpu_data, NOP);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_fetch(vecs[i].addr, vecs[i].gap, -1, got);
      chk($sformatf("tbl_hit_%0d", i), 32'(got), 32'(vecs[i].exp_hit));
    end

    // Reset in the middle of a refill, after two beats.
    cpu_req = 1'b1; cpu_addr = 32'h0000_07A0;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1; mem_rdata = memfn(32'h0000_07A0 + 32'(4 * b));
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0; cpu_req = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_cpu_valid", 32'(cpu_valid), 32'd0);
    chk("midrst_cpu_data", cpu_data, NOP);
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_fetch(32'h0000_0100, 0, -1, got);
    chk("postrst_miss", 32'(got), 32'd0);
    do_fetch(32'h0000_0108, 0, -1, got);
    chk("postrst_hit", 32'(got), 32'd1);

`ifdef ICACHE_FLUSH_EN
    do_fetch(32'h0000_0100, 0, -1, got);
    chk("fl_prehit", 32'(got), 32'd1);
    cpu_req = 1'b1; cpu_addr = 32'h0000_0100; flush = 1'b1;
    @(negedge clk);
    chk("fl_idle_valid", 32'(cpu_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; cpu_req = 1'b0;
    model_clear();
    do_fetch(32'h0000_0100, 0, -1, got);
    chk("fl_after_miss", 32'(got), 32'd0);
    do_fetch(32'h0000_0204, 1, 2, got);
    chk("fl_refill_miss", 32'(got), 32'd0);
    do_fetch(32'h0000_0208, 0, -1, got);
    chk("fl_line_invalid", 32'(got), 32'd0);
`endif

    // Randomized fetches over a small address window so hits and conflicts both occur.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          fb;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fb = -1;
`ifdef ICACHE_FLUSH_EN
      if ($urandom_range(0, 15) == 0) fb = int'($urandom_range(0, LW - 1));
`endif
      do_fetch(a, int'($urandom_range(0, 2)), fb, got);
    end

    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
